// File: rtl/tmds_decoder_dvi.sv
// TMDS receive decoder for one DVI channel: symbol-boundary alignment by bitslip
// requests, followed by control-token / 8b pixel decode with a one-cycle registered latency.
module tmds_decoder_dvi #(
    parameter int unsigned CTRL_MIN   = 32,
    parameter int unsigned SEARCH_MAX = 4096,
    parameter int unsigned SLIP_WAIT  = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [9:0] i_tmds,
    output logic       o_bitslip,
    output logic       o_locked,
    output logic       o_de,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl
);

    localparam int unsigned RUN_W  = $clog2(CTRL_MIN + 1);
    localparam int unsigned TO_W   = $clog2(SEARCH_MAX + 1);
    // +2 keeps the width at least one bit even when SLIP_WAIT is 0
    localparam int unsigned SLIP_W = $clog2(SLIP_WAIT + 2);

    localparam logic [RUN_W-1:0]  RUN_MAX   = RUN_W'(CTRL_MIN);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_MIN - 1);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(SEARCH_MAX - 1);
    localparam logic [SLIP_W-1:0] SLIP_LAST = SLIP_W'(SLIP_WAIT);

    typedef enum logic [1:0] {
        StSearch,
        StSlip,
        StLocked
    } state_t;

    state_t            state;
    logic [RUN_W-1:0]  run;
    logic [TO_W-1:0]   timeout;
    logic [SLIP_W-1:0] slip_cnt;

    logic       is_ctrl;
    logic [1:0] ctrl_val;
    logic [7:0] t;
    logic [7:0] data_dec;
    logic       run_done;

    // Combinational symbol classification and data decode
    always_comb begin
        is_ctrl  = 1'b1;
        ctrl_val = 2'b00;
        case (i_tmds)
            10'b1101010100: ctrl_val = 2'b00;
            10'b0010101011: ctrl_val = 2'b01;
            10'b0101010100: ctrl_val = 2'b10;
            10'b1010101011: ctrl_val = 2'b11;
            default:        is_ctrl  = 1'b0;
        endcase

        t           = i_tmds[9] ? ~i_tmds[7:0] : i_tmds[7:0];
        data_dec    = 8'h00;
        data_dec[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            data_dec[i] = i_tmds[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end

        // Edge on which the control-token run reaches CTRL_MIN
        run_done = is_ctrl && (run == RUN_LAST);
    end

    // Alignment FSM, counters and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= StSearch;
            run       <= '0;
            timeout   <= '0;
            slip_cnt  <= '0;
            o_bitslip <= 1'b0;
            o_locked  <= 1'b0;
            o_de      <= 1'b0;
            o_data    <= 8'h00;
            o_ctrl    <= 2'b00;
        end else begin
            o_bitslip <= 1'b0;

            // Output decode follows the state held before this edge
            if (state == StLocked) begin
                if (is_ctrl) begin
                    o_de   <= 1'b0;
                    o_data <= 8'h00;
                    o_ctrl <= ctrl_val;
                end else begin
                    o_de   <= 1'b1;
                    o_data <= data_dec;
                end
            end else begin
                o_de   <= 1'b0;
                o_data <= 8'h00;
                o_ctrl <= 2'b00;
            end

            case (state)
                StSearch, StLocked: begin
                    if (!is_ctrl) begin
                        run <= '0;
                    end else if (run != RUN_MAX) begin
                        run <= run + 1'b1;
                    end

                    if (run_done) begin
                        // Lock wins over a simultaneous timeout in both states
                        timeout <= '0;
                        if (state == StSearch) begin
                            state    <= StLocked;
                            o_locked <= 1'b1;
                        end
                    end else if (timeout == TO_LAST) begin
                        timeout <= '0;
                        if (state == StSearch) begin
                            state     <= StSlip;
                            o_bitslip <= 1'b1;
                            run       <= '0;
                            slip_cnt  <= '0;
                        end else begin
                            // Lost lock: fall back to searching, no immediate slip
                            state    <= StSearch;
                            o_locked <= 1'b0;
                        end
                    end else begin
                        timeout <= timeout + 1'b1;
                    end
                end

                StSlip: begin
                    run     <= '0;
                    timeout <= '0;
                    if (slip_cnt == SLIP_LAST) begin
                        state <= StSearch;
                    end else begin
                        slip_cnt <= slip_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= StSearch;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_decoder_dvi.sv
// Self-checking bench for tmds_decoder_dvi: directed symbol sequences, scoreboard of
// expected outputs pushed at drive time and popped one edge later.
module tb_tmds_decoder_dvi;

    localparam int unsigned CTRL_MIN   = 32;
    localparam int unsigned SEARCH_MAX = 64;
    localparam int unsigned SLIP_WAIT  = 4;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;
    localparam logic [9:0] DAT_A = 10'b0100000000;  // decodes to 0x00
    localparam logic [9:0] DAT_B = 10'b1011111111;  // decodes to 0xFE
    localparam logic [9:0] DAT_C = 10'b0111000011;

    typedef struct packed {
        logic       locked;
        logic       slip;
        logic       de;
        logic [7:0] data;
        logic [1:0] ctrl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] tmds;
    logic       bitslip;
    logic       locked;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic prev_lock;
    logic [1:0] held_ctrl;

    always #5 clk = ~clk;

    tmds_decoder_dvi #(
        .CTRL_MIN  (CTRL_MIN),
        .SEARCH_MAX(SEARCH_MAX),
        .SLIP_WAIT (SLIP_WAIT)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_tmds   (tmds),
        .o_bitslip(bitslip),
        .o_locked (locked),
        .o_de     (de),
        .o_data   (data),
        .o_ctrl   (ctrl)
    );

    // Returns {is_token, value}
    function automatic logic [2:0] tok(input logic [9:0] s);
        case (s)
            TOK00:   return 3'b100;
            TOK01:   return 3'b101;
            TOK10:   return 3'b110;
            TOK11:   return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [7:0] dec(input logic [9:0] s);
        logic [7:0] t;
        logic [7:0] d;
        t    = s[9] ? ~s[7:0] : s[7:0];
        d    = 8'h00;
        d[0] = t[0];
        for (int i = 1; i < 8; i++) begin
            d[i] = s[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
        end
        return d;
    endfunction

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One symbol: lock_e/slip_e are the required o_locked/o_bitslip after this edge
    task automatic step(input logic [9:0] sym, input logic lock_e, input logic slip_e,
                        input string tag);
        exp_t       e;
        exp_t       got;
        logic [2:0] tk;
        tk       = tok(sym);
        e.locked = lock_e;
        e.slip   = slip_e;
        if (prev_lock) begin
            if (tk[2]) begin
                e.de      = 1'b0;
                e.data    = 8'h00;
                held_ctrl = tk[1:0];
            end else begin
                e.de   = 1'b1;
                e.data = dec(sym);
            end
            e.ctrl = held_ctrl;
        end else begin
            e.de      = 1'b0;
            e.data    = 8'h00;
            e.ctrl    = 2'b00;
            held_ctrl = 2'b00;
        end
        prev_lock = lock_e;
        sb.push_back(e);
        tmds = sym;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check({tag, ".locked"},  10'(locked),  10'(got.locked));
        check({tag, ".bitslip"}, 10'(bitslip), 10'(got.slip));
        check({tag, ".de"},      10'(de),      10'(got.de));
        check({tag, ".data"},    10'(data),    10'(got.data));
        check({tag, ".ctrl"},    10'(ctrl),    10'(got.ctrl));
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, ".locked"},  10'(locked),  10'd0);
        check({tag, ".bitslip"}, 10'(bitslip), 10'd0);
        check({tag, ".de"},      10'(de),      10'd0);
        check({tag, ".data"},    10'(data),    10'd0);
        check({tag, ".ctrl"},    10'(ctrl),    10'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        prev_lock = 1'b0;
        held_ctrl = 2'b00;
        sb.delete();
    endtask

    initial begin
        rst_n     = 1'b1;
        tmds      = 10'd0;
        prev_lock = 1'b0;
        held_ctrl = 2'b00;
        #2;
        do_reset("rst_init");

        // Lock acquire; the final token coincides with the search timeout, lock wins
        for (int k = 1; k <= 31; k++) step(TOK00, 1'b0, 1'b0, $sformatf("acq_t00_%0d", k));
        step(DAT_A, 1'b0, 1'b0, "acq_break");
        for (int k = 1; k <= 31; k++) step(TOK10, 1'b0, 1'b0, $sformatf("acq_t10_%0d", k));
        step(TOK10, 1'b1, 1'b0, "acq_lock");
        step(TOK10, 1'b1, 1'b0, "acq_ctrl10");
        check("acq_ctrl10_lit", 10'(ctrl), 10'd2);

        // Locked decode
        step(DAT_A, 1'b1, 1'b0, "dec_a");
        check("dec_a_lit", 10'(data), 10'h000);
        step(DAT_B, 1'b1, 1'b0, "dec_b");
        check("dec_b_lit", 10'(data), 10'h0fe);
        step(TOK01, 1'b1, 1'b0, "dec_tok01");
        step(DAT_C, 1'b1, 1'b0, "dec_c");
        check("dec_c_ctrl_hold", 10'(ctrl), 10'd1);

        // Reset mid-stream while outputs are active
        do_reset("rst_mid");

        // Slip search: pulses at 64, 64+69, 64+2*69
        for (int k = 1; k <= 202; k++) begin
            step(DAT_C, 1'b0, (k == 64 || k == 133 || k == 202), $sformatf("slip_%0d", k));
        end
        // Reset in the first SLIP cycle cancels the pending pulse
        do_reset("rst_slip");

        // Lock loss after 64 data cycles, then a full search window before a slip
        for (int k = 1; k <= 32; k++) step(TOK11, (k == 32), 1'b0, $sformatf("loss_acq_%0d", k));
        for (int k = 1; k <= 64; k++) step(DAT_B, (k != 64), 1'b0, $sformatf("loss_d_%0d", k));
        for (int k = 1; k <= 64; k++) step(DAT_B, 1'b0, (k == 64), $sformatf("loss_s_%0d", k));
        do_reset("rst_loss");

        // Run completes on the same edge the locked timeout expires
        for (int k = 1; k <= 32; k++) step(TOK00, (k == 32), 1'b0, $sformatf("bnd_acq_%0d", k));
        for (int k = 1; k <= 32; k++) step(DAT_A, 1'b1, 1'b0, $sformatf("bnd_d_%0d", k));
        for (int k = 1; k <= 32; k++) step(TOK11, 1'b1, 1'b0, $sformatf("bnd_t_%0d", k));
        for (int k = 1; k <= 63; k++) step(DAT_B, 1'b1, 1'b0, $sformatf("bnd_hold_%0d", k));
        step(DAT_B, 1'b0, 1'b0, "bnd_drop");
        step(DAT_B, 1'b0, 1'b0, "bnd_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
